// File: rtl/token_policer.sv
// Token-bucket traffic policer: beats conform while the bucket holds TOKEN_COST,
// a run of VIOL_LIMIT violations locks the stream out until the bucket refills.
module token_policer #(
    parameter int DEN        = 16,
    parameter int RATE_NUM   = 3,
    parameter int BURST_MAX  = 8,
    parameter int TOKEN_COST = DEN,
    parameter int DW         = 8,
    parameter int DROP_EN    = 1,
    parameter int VIOL_LIMIT = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DW-1:0]    in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DW-1:0]    out_data_o,
    output logic             out_conform_o,
    output logic             block_o,
    output logic [CNT_W-1:0] conform_cnt_o,
    output logic [CNT_W-1:0] violate_cnt_o
);

    localparam int TOK_MAX = BURST_MAX * DEN;
    localparam int TOK_W   = $clog2(TOK_MAX + RATE_NUM + 1);
    localparam int STRK_W  = $clog2(VIOL_LIMIT + 1);

    localparam logic [TOK_W-1:0]  TOK_MAX_V = TOK_W'(TOK_MAX);
    localparam logic [TOK_W-1:0]  RATE_V    = TOK_W'(RATE_NUM);
    localparam logic [TOK_W-1:0]  COST_V    = TOK_W'(TOKEN_COST);
    localparam logic [STRK_W-1:0] VIOL_LAST = STRK_W'(VIOL_LIMIT - 1);

    typedef enum logic [0:0] {
        ST_OK    = 1'b0,
        ST_BLOCK = 1'b1
    } state_t;

    function automatic logic [TOK_W-1:0] clamp_tok(input logic [TOK_W-1:0] v);
        return (v > TOK_MAX_V) ? TOK_MAX_V : v;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t              state, state_next;
    logic [STRK_W-1:0]   streak, streak_next;
    logic [TOK_W-1:0]    tokens, tokens_next, eff;
    logic                accept, conform, violate, load;

    logic                vld_p1;
    logic [DW-1:0]       data_p1;
    logic                conform_p1;
    logic [CNT_W-1:0]    conform_cnt, violate_cnt;

    // Stage 0: admission, token accounting and classification
    assign in_ready_o = !vld_p1 || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign eff        = clamp_tok(tokens + RATE_V);

    always_comb begin
        state_next  = state;
        streak_next = streak;
        conform     = 1'b0;
        violate     = 1'b0;
        load        = 1'b0;
        case (state)
            ST_OK: begin
                if (accept) begin
                    if (eff >= COST_V) begin
                        conform     = 1'b1;
                        load        = 1'b1;
                        streak_next = '0;
                    end else begin
                        violate     = 1'b1;
                        load        = (DROP_EN == 0);
                        streak_next = streak + STRK_W'(1);
                        if (streak == VIOL_LAST) begin
                            state_next = ST_BLOCK;
                        end
                    end
                end
            end
            ST_BLOCK: begin
                // Nothing is charged here, so the next token value is eff itself.
                violate = accept;
                if (eff == TOK_MAX_V) begin
                    state_next  = ST_OK;
                    streak_next = '0;
                end
            end
            default: begin
                state_next = ST_OK;
            end
        endcase
    end

    assign tokens_next = conform ? (eff - COST_V) : eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_OK;
            streak <= '0;
            tokens <= TOK_MAX_V;
        end else begin
            state  <= state_next;
            streak <= streak_next;
            tokens <= tokens_next;
        end
    end

    // Stage 1: registered output beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            data_p1    <= '0;
            conform_p1 <= 1'b0;
        end else if (load) begin
            vld_p1     <= 1'b1;
            data_p1    <= in_data_i;
            conform_p1 <= conform;
        end else if (out_ready_i) begin
            vld_p1     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conform_cnt <= '0;
            violate_cnt <= '0;
        end else begin
            if (conform) begin
                conform_cnt <= sat_inc(conform_cnt);
            end
            if (violate) begin
                violate_cnt <= sat_inc(violate_cnt);
            end
        end
    end

    assign out_valid_o   = vld_p1;
    assign out_data_o    = data_p1;
    assign out_conform_o = conform_p1;
    assign block_o       = (state == ST_BLOCK);
    assign conform_cnt_o = conform_cnt;
    assign violate_cnt_o = violate_cnt;

endmodule
